// File: rtl/result_tx_sequencer.sv
// -----------------------------------------------------------------------------
// result_tx_sequencer
//
// Takes one ALU result word through a valid/ready handshake. It then sends the
// low (len_m1 + 1) bytes of that word, most significant first, to the UART
// transmitter through a second valid/ready handshake. A one-cycle done pulse
// marks the end of each word.
//
// Ports
//   clk_i        : system clock, rising-edge active
//   rst_ni       : asynchronous active-low reset
//   in_valid_i   : in_data_i / in_len_m1_i are valid
//   in_ready_o   : word can be accepted (IDLE only)
//   in_data_i    : result word
//   in_len_m1_i  : number of bytes to send minus one
//   tx_valid_o   : tx_data_o holds a byte for the UART
//   tx_ready_i   : UART takes the byte this cycle
//   tx_data_o    : byte to transmit
//   busy_o       : high while a word is being sent or completed
//   done_o       : one-cycle pulse after the last byte is accepted
//
// Every output comes from a flop. Each flop is loaded from the next-state
// decode, so the outputs line up with the state register and no input
// reaches an output combinationally.
// -----------------------------------------------------------------------------
module result_tx_sequencer #(
    parameter int DATA_W    = 32,
    parameter int MAX_BYTES = DATA_W / 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic [1:0]        in_len_m1_i,
    output logic              tx_valid_o,
    input  logic              tx_ready_i,
    output logic [7:0]        tx_data_o,
    output logic              busy_o,
    output logic              done_o
);

    localparam int IDX_W = $clog2(MAX_BYTES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_r;
    state_t              state_s;
    logic [DATA_W-1:0]   word_r;
    logic [DATA_W-1:0]   word_s;
    logic [IDX_W-1:0]    idx_r;
    logic [IDX_W-1:0]    idx_s;

    logic                in_ready_s;
    logic                tx_valid_s;
    logic [7:0]          tx_data_s;
    logic                busy_s;
    logic                done_s;

    // Returns byte number idx of the word. Byte 0 is the least significant.
    function automatic logic [7:0] byte_sel(input logic [DATA_W-1:0] w,
                                            input logic [IDX_W-1:0]  idx);
        return w[{idx, 3'b000} +: 8];
    endfunction

    // State, captured word and byte index registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r <= IDLE;
            word_r  <= {DATA_W{1'b0}};
            idx_r   <= {IDX_W{1'b0}};
        end else begin
            state_r <= state_s;
            word_r  <= word_s;
            idx_r   <= idx_s;
        end
    end

    // Next-state logic and next-output decode.
    always_comb begin
        state_s = state_r;
        word_s  = word_r;
        idx_s   = idx_r;

        case (state_r)
            IDLE: begin
                // in_ready_o is high in IDLE, so in_valid_i alone is enough
                // to complete the handshake.
                if (in_valid_i && in_ready_o) begin
                    word_s  = in_data_i;
                    idx_s   = in_len_m1_i;
                    state_s = SEND;
                end else begin
                    state_s = IDLE;
                end
            end
            SEND: begin
                if (tx_ready_i) begin
                    // The last byte always has index 0, so the index never
                    // underflows.
                    if (idx_r != {IDX_W{1'b0}}) begin
                        idx_s = idx_r - {{(IDX_W-1){1'b0}}, 1'b1};
                    end else begin
                        state_s = DONE;
                    end
                end else begin
                    state_s = SEND;
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase

        in_ready_s = (state_s == IDLE);
        tx_valid_s = (state_s == SEND);
        busy_s     = (state_s != IDLE);
        done_s     = (state_s == DONE);
        if (state_s == SEND) begin
            tx_data_s = byte_sel(word_s, idx_s);
        end else begin
            tx_data_s = 8'h00;
        end
    end

    // Output registers, loaded with the decode of the next state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            in_ready_o <= 1'b1;
            tx_valid_o <= 1'b0;
            tx_data_o  <= 8'h00;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
        end else begin
            in_ready_o <= in_ready_s;
            tx_valid_o <= tx_valid_s;
            tx_data_o  <= tx_data_s;
            busy_o     <= busy_s;
            done_o     <= done_s;
        end
    end

endmodule

// File: tb/tb_result_tx_sequencer.sv
// -----------------------------------------------------------------------------
// tb_result_tx_sequencer
//
// Self-checking bench for result_tx_sequencer. Inputs are driven and outputs
// are sampled on the falling clock edge. The reference model builds, for each
// word, the queue of bytes it should produce. A byte is popped from that
// queue each time a valid/ready handshake completes.
// -----------------------------------------------------------------------------
module tb_result_tx_sequencer;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [31:0] in_data_i;
    logic [1:0]  in_len_m1_i;
    logic        tx_valid_o;
    logic        tx_ready_i;
    logic [7:0]  tx_data_o;
    logic        busy_o;
    logic        done_o;

    int errors = 0;
    int checks = 0;

    result_tx_sequencer dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_data_i   (in_data_i),
        .in_len_m1_i (in_len_m1_i),
        .tx_valid_o  (tx_valid_o),
        .tx_ready_i  (tx_ready_i),
        .tx_data_o   (tx_data_o),
        .busy_o      (busy_o),
        .done_o      (done_o)
    );

    always #5 clk_i = ~clk_i;

    // Global time limit on the whole run.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Sends one word and checks every cycle of it.
    // mode 0: tx_ready held high.
    // mode 1: the first 8 cycles follow pat[i], then tx_ready is high.
    // mode 2: tx_ready is random.
    // After accept, in_data_i is set to post_data. If hold_valid is set,
    // in_valid_i stays high with post_data/hold_len.
    task automatic run_word(input logic [31:0] w, input logic [1:0] l, input int mode,
                            input logic [7:0] pat, input logic [31:0] post_data,
                            input logic hold_valid, input logic [1:0] hold_len);
        logic [7:0] exp_q[$];
        logic       r;
        int         cyc;
        chk("idle_in_ready", {31'd0, in_ready_o}, 32'd1);
        in_valid_i  = 1'b1;
        in_data_i   = w;
        in_len_m1_i = l;
        tx_ready_i  = 1'($urandom_range(0, 1));
        for (int k = int'(l); k >= 0; k--) begin
            exp_q.push_back(8'((w >> (8 * k)) & 32'hFF));
        end
        @(negedge clk_i);
        in_valid_i  = hold_valid;
        in_data_i   = post_data;
        in_len_m1_i = hold_len;
        cyc = 0;
        while (exp_q.size() > 0 && cyc < 200) begin
            chk("tx_valid",      {31'd0, tx_valid_o}, 32'd1);
            chk("tx_data",       {24'd0, tx_data_o},  {24'd0, exp_q[0]});
            chk("in_ready_send", {31'd0, in_ready_o}, 32'd0);
            chk("busy_send",     {31'd0, busy_o},     32'd1);
            chk("done_send",     {31'd0, done_o},     32'd0);
            case (mode)
                0:       r = 1'b1;
                1:       r = (cyc < 8) ? pat[cyc] : 1'b1;
                default: r = 1'($urandom_range(0, 1));
            endcase
            tx_ready_i = r;
            @(negedge clk_i);
            if (r) begin
                void'(exp_q.pop_front());
            end
            cyc++;
        end
        chk("no_timeout", exp_q.size(), 32'd0);
        tx_ready_i = 1'($urandom_range(0, 1));
        chk("done_pulse",    {31'd0, done_o},     32'd1);
        chk("tx_valid_done", {31'd0, tx_valid_o}, 32'd0);
        chk("in_ready_done", {31'd0, in_ready_o}, 32'd0);
        chk("busy_done",     {31'd0, busy_o},     32'd1);
        @(negedge clk_i);
        chk("done_cleared",  {31'd0, done_o},     32'd0);
        chk("in_ready_back", {31'd0, in_ready_o}, 32'd1);
        chk("busy_cleared",  {31'd0, busy_o},     32'd0);
        chk("tx_valid_idle", {31'd0, tx_valid_o}, 32'd0);
    endtask

    initial begin
        rst_ni      = 1'b0;
        in_valid_i  = 1'b0;
        in_data_i   = 32'h0;
        in_len_m1_i = 2'd0;
        tx_ready_i  = 1'b0;

        // Outputs while reset is held.
        @(negedge clk_i);
        @(negedge clk_i);
        chk("rst_in_ready", {31'd0, in_ready_o}, 32'd1);
        chk("rst_tx_valid", {31'd0, tx_valid_o}, 32'd0);
        chk("rst_tx_data",  {24'd0, tx_data_o},  32'd0);
        chk("rst_busy",     {31'd0, busy_o},     32'd0);
        chk("rst_done",     {31'd0, done_o},     32'd0);
        rst_ni = 1'b1;
        @(negedge clk_i);

        // Four bytes with tx_ready held high.
        run_word(32'hDEADBEEF, 2'd3, 0, 8'h00, 32'h0, 1'b0, 2'd0);
        // One byte.
        run_word(32'h12345678, 2'd0, 0, 8'h00, 32'h0, 1'b0, 2'd0);
        // Fixed stall pattern on tx_ready: 0,0,1,0,1,1,0,1.
        run_word(32'hCAFEF00D, 2'd3, 1, 8'b1011_0100, 32'h0, 1'b0, 2'd0);
        // A second word is held valid during the first. It must wait, then send AA x4.
        run_word(32'hDEADBEEF, 2'd3, 0, 8'h00, 32'hAAAAAAAA, 1'b1, 2'd3);
        run_word(32'hAAAAAAAA, 2'd3, 0, 8'h00, 32'h0, 1'b0, 2'd0);

        // Reset after BE has been accepted, while EF is being presented.
        chk("pre_abort_ready", {31'd0, in_ready_o}, 32'd1);
        in_valid_i  = 1'b1;
        in_data_i   = 32'hDEADBEEF;
        in_len_m1_i = 2'd3;
        tx_ready_i  = 1'b1;
        @(negedge clk_i);
        in_valid_i = 1'b0;
        in_data_i  = $urandom;
        @(negedge clk_i);
        @(negedge clk_i);
        @(negedge clk_i);
        chk("abort_pre_data",  {24'd0, tx_data_o},  32'hEF);
        chk("abort_pre_valid", {31'd0, tx_valid_o}, 32'd1);
        rst_ni = 1'b0;
        #1;
        chk("abort_tx_valid", {31'd0, tx_valid_o}, 32'd0);
        chk("abort_in_ready", {31'd0, in_ready_o}, 32'd1);
        chk("abort_done",     {31'd0, done_o},     32'd0);
        chk("abort_busy",     {31'd0, busy_o},     32'd0);
        @(negedge clk_i);
        chk("abort_done_hold", {31'd0, done_o}, 32'd0);
        rst_ni = 1'b1;
        @(negedge clk_i);
        chk("post_abort_done",     {31'd0, done_o},     32'd0);
        chk("post_abort_tx_valid", {31'd0, tx_valid_o}, 32'd0);
        run_word(32'h0000BEEF, 2'd1, 0, 8'h00, 32'h0, 1'b0, 2'd0);

        // in_data_i is cleared one cycle after accept. BE, EF must still be sent.
        run_word(32'hDEADBEEF, 2'd1, 0, 8'h00, 32'h0, 1'b0, 2'd0);

        // Random words, lengths and tx_ready.
        for (int n = 0; n < 24; n++) begin
            run_word($urandom, 2'($urandom_range(0, 3)), 2, 8'h00, $urandom, 1'b0, 2'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
